// File: rtl/dma_cmpl_irq_unit_if.sv
// dma_cmpl_irq_unit_if: 64-bit single-cycle reg bus (addr/write/wdata/wstrb/valid request, rdata/error/ready response)
interface dma_cmpl_irq_unit_if;
  logic [5:0] addr;
  logic write;
  logic [63:0] wdata;
  logic [7:0] wstrb;
  logic valid;
  logic [63:0] rdata;
  logic error;
  logic ready;
  modport master (output addr, write, wdata, wstrb, valid, input rdata, error, ready);
  modport slave (input addr, write, wdata, wstrb, valid, output rdata, error, ready);
endinterface

// File: rtl/dma_cmpl_irq_unit.sv
// dma_cmpl_irq_unit: iDMA completion tracker with coalesced W1C interrupts; ports clk_i, rst_ni, issue/cmpl snoops, reg_bus slave, idle_o, irq_o
module dma_cmpl_irq_unit #(
  parameter int CntWidth = 64,
  parameter int ThrWidth = 16,
  parameter int TmoWidth = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic issue_valid_i,
  input  logic issue_ready_i,
  input  logic cmpl_valid_i,
  dma_cmpl_irq_unit_if.slave reg_bus,
  output logic idle_o,
  output logic [1:0] irq_o
);
  logic [CntWidth-1:0] issued, done;
  logic [ThrWidth-1:0] coal_thr, pend_cnt, pend_inc, thr;
  logic [TmoWidth-1:0] coal_tmo, timer;
  logic [1:0] ipsr, ier, w1c;
  logic [63:0] wmask, wm, rdata;
  logic [2:0] off;
  logic mapped, wr, rd, issue_ev, cmpl_ok, spur, thr_hit, tmo_hit, cip_set;
  always_comb begin
    issue_ev = issue_valid_i & issue_ready_i;
    cmpl_ok = cmpl_valid_i & (((issued - done) != '0) | issue_ev);
    spur = cmpl_valid_i & ~cmpl_ok;
    thr = (coal_thr == '0) ? ThrWidth'(1) : coal_thr;
    pend_inc = pend_cnt + ThrWidth'(cmpl_ok);
    thr_hit = cmpl_ok & (pend_inc >= thr);
    tmo_hit = ~thr_hit & (pend_cnt != '0) & (coal_tmo != '0) & (timer == coal_tmo - TmoWidth'(1));
    cip_set = thr_hit | tmo_hit;
    off = reg_bus.addr[5:3];
    mapped = (off < 3'd6) & (reg_bus.addr[2:0] == 3'b0);
    wr = reg_bus.valid & mapped & reg_bus.write;
    rd = reg_bus.valid & mapped & ~reg_bus.write;
    wmask = '0;
    for (int b = 0; b < 8; b++) wmask[8*b +: 8] = {8{reg_bus.wstrb[b]}};
    wm = reg_bus.wdata & wmask;
    w1c = (wr && off == 3'd2) ? 2'(wm) : 2'b0;
    rdata = off == 3'd0 ? 64'(issued) :
            off == 3'd1 ? 64'(done) :
            off == 3'd2 ? 64'(ipsr) :
            off == 3'd3 ? 64'(ier) :
            off == 3'd4 ? 64'(coal_thr) : 64'(coal_tmo);
    reg_bus.rdata = rd ? rdata : '0;
    reg_bus.error = reg_bus.valid & ~mapped;
    reg_bus.ready = reg_bus.valid;
    idle_o = issued == done;
    irq_o = ipsr & ier;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued <= '0;
      done <= '0;
      pend_cnt <= '0;
      timer <= '0;
      ipsr <= '0;
      ier <= '0;
      coal_thr <= '0;
      coal_tmo <= '0;
    end else begin
      issued <= issued + CntWidth'(issue_ev);
      done <= done + CntWidth'(cmpl_ok);
      pend_cnt <= cip_set ? '0 : pend_inc;
      timer <= (cip_set || pend_cnt == '0 || coal_tmo == '0) ? '0 : timer + TmoWidth'(1);
      ipsr <= {spur | (ipsr[1] & ~w1c[1]), cip_set | (ipsr[0] & ~w1c[0])};
      if (wr && off == 3'd3) ier <= 2'((64'(ier) & ~wmask) | wm);
      if (wr && off == 3'd4) coal_thr <= ThrWidth'((64'(coal_thr) & ~wmask) | wm);
      if (wr && off == 3'd5) coal_tmo <= TmoWidth'((64'(coal_tmo) & ~wmask) | wm);
    end
  end
endmodule
